// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one registered add/subtract stage between two requesters.
// Optional per-requester saturating issue counters: define ALU_SHARE_SCHED_STATS_EN.
module alu_share_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag
`ifdef ALU_SHARE_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic             last_q;
    logic             accept;
    logic             grant0, grant1, xfer;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_op;
    logic [WIDTH:0]   result;

    // Ready is a function of the other port's valid only, so the grant never loops on itself.
    assign accept     = (state_q == EMPTY) | rsp_ready;
    assign req0_ready = accept & (!req1_valid | last_q);
    assign req1_ready = accept & (!req0_valid | !last_q);
    assign grant0     = req0_valid & req0_ready;
    assign grant1     = req1_valid & req1_ready;
    assign xfer       = grant0 | grant1;
    assign rsp_valid  = (state_q == FULL);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_op = req0_op;
        if (grant1) begin
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_op = req1_op;
        end
        // The extra top bit is the carry for add and the borrow (a < b) for subtract.
        if (sel_op)
            result = {1'b0, sel_a} - {1'b0, sel_b};
        else
            result = {1'b0, sel_a} + {1'b0, sel_b};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (rsp_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            last_q   <= 1'b1;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                last_q   <= grant1;
                rsp_id   <= grant1;
                rsp_data <= result[WIDTH-1:0];
                rsp_flag <= result[WIDTH];
            end
        end
    end

`ifdef ALU_SHARE_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (grant1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed self-checking bench for alu_share_sched: arithmetic, arbitration, backpressure, reset.
// Stats checks are compiled in only with ALU_SHARE_SCHED_STATS_EN.
module tb_alu_share_sched;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_flag;
    logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SHARE_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag)
`ifdef ALU_SHARE_SCHED_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [WIDTH-1:0] data,
                             input logic flag);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".data"},  32'(rsp_data),  32'(data));
        check({tag, ".flag"},  32'(rsp_flag),  32'(flag));
    endtask

    initial begin
        logic exp_id;

        rst = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 1'b1;
        #2;
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.id",    32'(rsp_id),    32'd0);
        check("rst.data",  32'(rsp_data),  32'd0);
        check("rst.flag",  32'(rsp_flag),  32'd0);
        check("rst.rdy0",  32'(req0_ready), 32'd1);
        check("rst.rdy1",  32'(req1_ready), 32'd1);
`ifdef ALU_SHARE_SCHED_STATS_EN
        check("rst.cnt0", 32'(cnt0), 32'd0);
        check("rst.cnt1", 32'(cnt1), 32'd0);
`endif
        #10;
        rst = 1'b1;

        // 3 + 4 from requester 0
        req0_valid = 1; req0_a = 4'h3; req0_b = 4'h4; req0_op = 0;
        #1;
        check("add.rdy0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 0;
        check_rsp("add", 1'b0, 4'h7, 1'b0);

        // 2 - 5 from requester 1 borrows
        req1_valid = 1; req1_a = 4'h2; req1_b = 4'h5; req1_op = 1;
        #1;
        check("sub.rdy1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 0;
        check_rsp("sub", 1'b1, 4'hD, 1'b1);

        // F + 1 overflows
        req0_valid = 1; req0_a = 4'hF; req0_b = 4'h1; req0_op = 0;
        #1;
        check("ovf.rdy0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 0;
        check_rsp("ovf", 1'b0, 4'h0, 1'b1);

        step();
        check("drain.valid", 32'(rsp_valid), 32'd0);

        // Contention after a req0 grant: req1 wins first
        req0_valid = 1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 0;
        req1_valid = 1; req1_a = 4'h6; req1_b = 4'h3; req1_op = 1;
        #1;
        check("cont.rdy0", 32'(req0_ready), 32'd0);
        check("cont.rdy1", 32'(req1_ready), 32'd1);
        step();
        check_rsp("cont", 1'b1, 4'h3, 1'b0);

        // Backpressure: hold for 5 cycles
        rsp_ready = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp.rdy0", 32'(req0_ready), 32'd0);
            check("bp.rdy1", 32'(req1_ready), 32'd0);
            step();
            check_rsp("bp", 1'b1, 4'h3, 1'b0);
        end
        rsp_ready = 1;
        #1;
        check("bp_rel.rdy0", 32'(req0_ready), 32'd1);
        check("bp_rel.rdy1", 32'(req1_ready), 32'd0);
        step();
        check_rsp("bp_rel", 1'b0, 4'h2, 1'b0);

        // Asynchronous reset while FULL, between clock edges
        rsp_ready = 0;
        #2;
        rst = 0;
        #1;
        check("arst.valid", 32'(rsp_valid), 32'd0);
        check("arst.data",  32'(rsp_data),  32'd0);
        #1;
        rst = 1;
        rsp_ready = 1;
        #1;
        check("arst.rdy0", 32'(req0_ready), 32'd1);
        check("arst.rdy1", 32'(req1_ready), 32'd0);

        // Continuous contention alternates 0,1,0,1 starting with 0
        exp_id = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (exp_id)
                check_rsp("rr", 1'b1, 4'h3, 1'b0);
            else
                check_rsp("rr", 1'b0, 4'h2, 1'b0);
            exp_id = !exp_id;
        end

`ifdef ALU_SHARE_SCHED_STATS_EN
        check("rr.cnt0", 32'(cnt0), 32'd4);
        check("rr.cnt1", 32'(cnt1), 32'd4);
        repeat (600) step();
        check("sat.cnt0", 32'(cnt0), 32'hFF);
        check("sat.cnt1", 32'(cnt1), 32'hFF);
`endif

        req0_valid = 0;
        req1_valid = 0;
        step();
        step();
        check("end.valid", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
